// File: rtl/regfile_dump.sv
// Streams a contiguous range of register-file entries out over valid/ready,
// reading through one asynchronous read port (one LOAD + one SEND per beat).
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [63:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [4:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic        last_q, last_d;
    logic        accept;

    assign accept    = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= FIRST;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        ra      = idx_q;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ra   = FIRST;
                busy = 1'b0;
                if (start) begin
                    idx_d   = FIRST;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = rd;
                addr_d  = idx_q;
                last_d  = (idx_q == LAST);
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    valid_d = 1'b0;
                    // Increment is skipped on the last beat so LAST_REG=31 cannot wrap idx.
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: behavioural register file with write-through
// reads, a table of expected beats, and hand sequences for the multi-cycle cases.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        out_valid, out_last, busy, done;
    logic [4:0]  out_addr;
    logic [63:0] out_data;

    logic        start2, ready2;
    logic [4:0]  ra2;
    logic [63:0] rd2;
    logic        out_valid2, out_last2, busy2, done2;
    logic [4:0]  out_addr2;
    logic [63:0] out_data2;

    logic        rf_init, we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [63:0] regs [32];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt  = 0;
    int done2_cnt = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        last;
    } beat_t;
    beat_t exp_tab [32];

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump #(.FIRST_REG(3), .LAST_REG(5)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ra(ra2), .rd(rd2),
        .out_valid(out_valid2), .out_ready(ready2), .out_addr(out_addr2),
        .out_data(out_data2), .out_last(out_last2), .busy(busy2), .done(done2)
    );

    // Register file model: x31 reads zero, a same-cycle write is forwarded.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 31) ? 64'd0 : 64'(i);
        end else if (we3 && wa3 != 5'd31) begin
            regs[wa3] <= wd3;
        end
    end

    always_comb begin
        if (ra == 5'd31)              rd = '0;
        else if (we3 && wa3 == ra)    rd = wd3;
        else                          rd = regs[ra];
    end

    assign rd2 = (ra2 == 5'd31) ? 64'd0 : regs[ra2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done)  done_cnt  <= done_cnt + 1;
        if (done2) done2_cnt <= done2_cnt + 1;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One full dump of dut; optional stall on one beat, start poke while busy,
    // and a forwarded write during the LOAD of one beat.
    task automatic do_dump(input int stall_at, input int stall_n, input bit poke, input int wt_at);
        int guard;
        int t0;
        int d0;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0; t0 = cyc;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 32; k++) begin
            if (k == wt_at) begin
                we3 = 1'b1; wa3 = 5'(k); wd3 = 64'hDEAD_BEEF;
            end
            guard = 0;
            while (!out_valid && guard < 10) begin
                @(negedge clk); guard++;
            end
            we3 = 1'b0;
            if (!out_valid) begin
                total++; bad++;
                $display("FAIL beat_timeout: beat %0d never valid (expected within 10 cycles)", k);
                return;
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_valid", {63'd0, out_valid}, 64'd1);
                    check("stall_addr", {59'd0, out_addr}, {59'd0, exp_tab[k].addr});
                    check("stall_data", out_data, exp_tab[k].data);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check("beat_addr", {59'd0, out_addr}, {59'd0, exp_tab[k].addr});
            check("beat_data", out_data, exp_tab[k].data);
            check("beat_last", {63'd0, out_last}, {63'd0, exp_tab[k].last});
            if (poke && k == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check("done_pulse", {63'd0, done}, 64'd1);
        check("done_latency", 64'(cyc - t0), 64'(64 + stall_n));
        @(negedge clk);
        check("done_low_after", {63'd0, done}, 64'd0);
        check("busy_low_after", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("idle_no_restart", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int guard;
        int n;
        int d0;

        for (int i = 0; i < 32; i++) begin
            exp_tab[i].addr = 5'(i);
            exp_tab[i].data = (i == 31) ? 64'd0 : 64'(i);
            exp_tab[i].last = (i == 31);
        end

        reset = 1'b1; rf_init = 1'b1; start = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_last", {63'd0, out_last}, 64'd0);
        check("rst_addr", {59'd0, out_addr}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_ra", {59'd0, ra}, 64'd0);
        check("rst_ra_p", {59'd0, ra2}, 64'd3);
        reset = 1'b0; rf_init = 1'b0;
        @(negedge clk);

        // Plain full dump, then stalled beat 7, then start poked while busy.
        do_dump(-1, 0, 1'b0, -1);
        do_dump(7, 5, 1'b0, -1);
        do_dump(-1, 0, 1'b1, -1);

        // Reset in SEND at beat 10 drops the beat; next dump restarts at 0.
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0; out_ready = 1'b0;
        guard = 0;
        while (!(out_valid && out_addr == 5'd10) && guard < 100) begin
            out_ready = 1'b1;
            @(negedge clk); guard++;
            if (out_valid && out_addr == 5'd10) out_ready = 1'b0;
        end
        out_ready = 1'b0;
        check("reach_beat10", {59'd0, out_addr}, 64'd10);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_addr", {59'd0, out_addr}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        do_dump(-1, 0, 1'b0, -1);

        // Narrow range 3..5 on the second instance.
        d0 = done2_cnt; n = 0;
        @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid2) begin
                check("rng_addr", {59'd0, out_addr2}, 64'(3 + n));
                check("rng_data", out_data2, 64'(3 + n));
                check("rng_last", {63'd0, out_last2}, {63'd0, (n == 2)});
                check("rng_ra", {59'd0, ra2}, 64'(3 + n));
                n++;
            end
            @(negedge clk);
        end
        check("rng_beats", 64'(n), 64'd3);
        check("rng_done_count", 64'(done2_cnt - d0), 64'd1);
        check("rng_busy_end", {63'd0, busy2}, 64'd0);
        check("rng_ra_idle", {59'd0, ra2}, 64'd3);

        // Forwarded write to x4 during its LOAD cycle.
        exp_tab[4].data = 64'hDEAD_BEEF;
        do_dump(-1, 0, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (limit 200000)");
        $fatal(1);
    end

endmodule
